tx_axis_pkt_arbiter: RTL and testbench
======================================

# tx_axis_pkt_arbiter

Packet-aware two-source arbiter for the simple_rdma TX AXI-Stream path, sharing one TX stream between the compute-unit source (cu_*) and the RDMA-engine source (re_*). Grants are held for a whole packet (switching only after a tlast beat is accepted), so packets are never interleaved. RE has priority, and a burst limit bounds CU starvation. Sits between the CU/RE TX generators and the interface TX datapath.

## Interface
- AXIS_DATA_WIDTH, 512: tdata width.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8: tkeep width.
- AXIS_TX_ID_WIDTH, 10: tid width.
- AXIS_TX_DEST_WIDTH, 4: tdest width.
- AXIS_TX_USER_WIDTH, 232: tuser width.
- RE_BURST_MAX, 4: consecutive RE packets allowed while CU waits; range 1..255.
- Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cu_tx_axis_{tdata,tkeep,tvalid,tlast,tid,tdest,tuser}  in  per params  CU source stream.
- cu_tx_axis_tready  out  1  CU ready.
- re_tx_axis_{tdata,tkeep,tvalid,tlast,tid,tdest,tuser}  in  per params  RE source stream.
- re_tx_axis_tready  out  1  RE ready.
- tx_axis_{tdata,tkeep,tvalid,tlast,tid,tdest,tuser}  out  per params  arbitrated stream.
- tx_axis_tready  in  1  downstream ready.
- grant  out  2  01 = CU owns output, 10 = RE owns output, 00 = idle.

## Operation
- States: IDLE, GNT_CU, GNT_RE (registered, 2 bits).
- IDLE: tx_axis_tvalid=0, both source treadys=0. Decision, evaluated every IDLE cycle on the current tvalid inputs:
  - RE only valid -> GNT_RE.
  - CU only valid -> GNT_CU.
  - Both valid: GNT_CU if burst_cnt == RE_BURST_MAX, else GNT_RE.
  - Neither valid -> stay IDLE.
- GNT_x: all tx_axis_* outputs driven combinationally from source x; x tready = tx_axis_tready; the other source's tready = 0.
- Handshake tx_axis_tvalid & tx_axis_tready & tx_axis_tlast -> IDLE next cycle. Grant is never changed mid-packet.
- burst_cnt (8 bits, reset 0):
  - Incremented at RE tlast handshake if cu_tx_axis_tvalid is high during that cycle, saturating at RE_BURST_MAX.
  - Cleared at RE tlast handshake when CU is not valid.
  - Cleared at CU tlast handshake.
- A source that drops tvalid mid-packet keeps the grant. Output tvalid follows the source. No timeout.
- Sources are AXIS-compliant: once tvalid is asserted, it stays high until the beat is accepted.

## Timing
- Reset: state=IDLE, grant=00, burst_cnt=0, tx_axis_tvalid=0, cu/re treadys=0. Data outputs are don't-care (driven 0 in IDLE).
- Arbitration costs one bubble cycle per packet: a request seen in IDLE at cycle N makes its first beat visible on tx_axis at cycle N+1.
- Within a packet, latency is 0 cycles; data, valid and ready are combinational passthrough with full throughput.
- Single-beat packet, tready high: IDLE, GNT, IDLE. Minimum 2 cycles per packet.
- Reset asserted mid-packet: immediate return to IDLE. Both treadys drop asynchronously. The partial packet is truncated, and the sources are responsible for recovery.
- Simultaneous new requests on an RE tlast handshake: the burst decision uses the incremented burst_cnt in the following IDLE cycle.

## Configuration
- TX_AXIS_ARB_STATS_EN defined: adds outputs stat_cu_pkts (32 bits, out) and stat_re_pkts (32 bits, out).
  - Each increments on its source's tlast handshake and wraps modulo 2^32.
  - Reset to 0 and also cleared by input stat_clr (1 bit, in, synchronous, priority over increment).
- TX_AXIS_ARB_STATS_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Package tx_arb_pkg contains:
  - state encoding constants ST_IDLE=2'd0, ST_GNT_CU=2'd1, ST_GNT_RE=2'd2;
  - grant encodings GNT_NONE, GNT_CU, GNT_RE;
  - BURST_CNT_W=8.
- Sub-module tx_axis_arb_grant: pure decision logic. Inputs are the two tvalids, burst_cnt and RE_BURST_MAX; output is the next-grant. Unit-testable on its own.
- The top holds the state register, burst counter, output muxing and optional stats.

## Test plan
- Reset, then RE-only 3-beat packet with tready=1 -> grant=10 at cycle 1, beats out at cycles 1-3, grant=00 at cycle 4; cu_tx_axis_tready stays 0 throughout.
- CU 4-beat packet in flight, RE asserts valid at beat 2 -> all CU beats complete uninterrupted, then one IDLE cycle, then RE first beat.
- Both sources continuously valid with 1-beat packets, RE_BURST_MAX=4 -> output source sequence RE,RE,RE,RE,CU,RE,RE,RE,RE,CU...
- tx_axis_tready toggled 1010 during RE 5-beat packet -> no beat lost or duplicated; re tready mirrors tx_axis_tready; grant held.
- rst_n asserted at beat 2 of a CU packet -> tx_axis_tvalid and cu_tx_axis_tready are 0 immediately; after release, state=IDLE and burst_cnt=0.
- With TX_AXIS_ARB_STATS_EN: 7 CU and 9 RE packets -> stat_cu_pkts=7, stat_re_pkts=9; pulse stat_clr -> both 0 next cycle.

Source files
------------

// File: rtl/tx_axis_pkt_arbiter_pkg.sv
// Shared encodings for the packet-aware TX AXI-Stream arbiter.
package tx_arb_pkg;
    localparam int BURST_CNT_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GNT_CU = 2'd1;
    localparam logic [1:0] ST_GNT_RE = 2'd2;

    // Grant encodings coincide with the state encodings, so grant is the state.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CU   = 2'b01;
    localparam logic [1:0] GNT_RE   = 2'b10;

    typedef enum logic [1:0] {
        STATE_IDLE = ST_IDLE,
        STATE_CU   = ST_GNT_CU,
        STATE_RE   = ST_GNT_RE
    } arb_state_e;
endpackage

// File: rtl/tx_axis_arb_grant.sv
// Pure next-grant decision: RE has priority unless CU has waited RE_BURST_MAX packets.
module tx_axis_arb_grant
    import tx_arb_pkg::*;
#(
    parameter int RE_BURST_MAX = 4
) (
    input  logic                   cu_valid,
    input  logic                   re_valid,
    input  logic [BURST_CNT_W-1:0] burst_cnt,
    output logic [1:0]             next_grant
);
    localparam logic [BURST_CNT_W-1:0] BURST_MAX_C = BURST_CNT_W'(RE_BURST_MAX);

    always_comb begin
        next_grant = GNT_NONE;
        if (cu_valid && re_valid)
            next_grant = (burst_cnt == BURST_MAX_C) ? GNT_CU : GNT_RE;
        else if (re_valid)
            next_grant = GNT_RE;
        else if (cu_valid)
            next_grant = GNT_CU;
    end
endmodule

// File: rtl/tx_axis_pkt_arbiter.sv
// Two-source packet arbiter for the TX AXI-Stream path; grants held for a whole packet.
// Optional packet counters enabled by defining TX_AXIS_ARB_STATS_EN.
module tx_axis_pkt_arbiter
    import tx_arb_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH    = 512,
    parameter int AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_TX_ID_WIDTH   = 10,
    parameter int AXIS_TX_DEST_WIDTH = 4,
    parameter int AXIS_TX_USER_WIDTH = 232,
    parameter int RE_BURST_MAX       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXIS_DATA_WIDTH-1:0]    cu_tx_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]    cu_tx_axis_tkeep,
    input  logic                          cu_tx_axis_tvalid,
    input  logic                          cu_tx_axis_tlast,
    input  logic [AXIS_TX_ID_WIDTH-1:0]   cu_tx_axis_tid,
    input  logic [AXIS_TX_DEST_WIDTH-1:0] cu_tx_axis_tdest,
    input  logic [AXIS_TX_USER_WIDTH-1:0] cu_tx_axis_tuser,
    output logic                          cu_tx_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]    re_tx_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]    re_tx_axis_tkeep,
    input  logic                          re_tx_axis_tvalid,
    input  logic                          re_tx_axis_tlast,
    input  logic [AXIS_TX_ID_WIDTH-1:0]   re_tx_axis_tid,
    input  logic [AXIS_TX_DEST_WIDTH-1:0] re_tx_axis_tdest,
    input  logic [AXIS_TX_USER_WIDTH-1:0] re_tx_axis_tuser,
    output logic                          re_tx_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]    tx_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]    tx_axis_tkeep,
    output logic                          tx_axis_tvalid,
    output logic                          tx_axis_tlast,
    output logic [AXIS_TX_ID_WIDTH-1:0]   tx_axis_tid,
    output logic [AXIS_TX_DEST_WIDTH-1:0] tx_axis_tdest,
    output logic [AXIS_TX_USER_WIDTH-1:0] tx_axis_tuser,
    input  logic                          tx_axis_tready,
    output logic [1:0]                    grant
`ifdef TX_AXIS_ARB_STATS_EN
   ,input  logic                          stat_clr,
    output logic [31:0]                   stat_cu_pkts,
    output logic [31:0]                   stat_re_pkts
`endif
);
    localparam logic [BURST_CNT_W-1:0] BURST_MAX_C = BURST_CNT_W'(RE_BURST_MAX);

    arb_state_e             state, state_n;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [1:0]             next_grant;
    logic                   cu_done, re_done;

    tx_axis_arb_grant #(.RE_BURST_MAX(RE_BURST_MAX)) u_grant (
        .cu_valid   (cu_tx_axis_tvalid),
        .re_valid   (re_tx_axis_tvalid),
        .burst_cnt  (burst_cnt),
        .next_grant (next_grant)
    );

    assign cu_done = (state == STATE_CU) && cu_tx_axis_tvalid && tx_axis_tready && cu_tx_axis_tlast;
    assign re_done = (state == STATE_RE) && re_tx_axis_tvalid && tx_axis_tready && re_tx_axis_tlast;
    assign grant   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= STATE_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n           = state;
        tx_axis_tdata     = '0;
        tx_axis_tkeep     = '0;
        tx_axis_tvalid    = 1'b0;
        tx_axis_tlast     = 1'b0;
        tx_axis_tid       = '0;
        tx_axis_tdest     = '0;
        tx_axis_tuser     = '0;
        cu_tx_axis_tready = 1'b0;
        re_tx_axis_tready = 1'b0;
        case (state)
            STATE_IDLE: state_n = arb_state_e'(next_grant);
            STATE_CU: begin
                tx_axis_tdata     = cu_tx_axis_tdata;
                tx_axis_tkeep     = cu_tx_axis_tkeep;
                tx_axis_tvalid    = cu_tx_axis_tvalid;
                tx_axis_tlast     = cu_tx_axis_tlast;
                tx_axis_tid       = cu_tx_axis_tid;
                tx_axis_tdest     = cu_tx_axis_tdest;
                tx_axis_tuser     = cu_tx_axis_tuser;
                cu_tx_axis_tready = tx_axis_tready;
                if (cu_done) state_n = STATE_IDLE;
            end
            STATE_RE: begin
                tx_axis_tdata     = re_tx_axis_tdata;
                tx_axis_tkeep     = re_tx_axis_tkeep;
                tx_axis_tvalid    = re_tx_axis_tvalid;
                tx_axis_tlast     = re_tx_axis_tlast;
                tx_axis_tid       = re_tx_axis_tid;
                tx_axis_tdest     = re_tx_axis_tdest;
                tx_axis_tuser     = re_tx_axis_tuser;
                re_tx_axis_tready = tx_axis_tready;
                if (re_done) state_n = STATE_IDLE;
            end
            default: state_n = STATE_IDLE;
        endcase
    end

    // Counts RE packets sent while CU was left waiting; any CU packet or an uncontended RE packet resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (re_done) begin
            if (!cu_tx_axis_tvalid)            burst_cnt <= '0;
            else if (burst_cnt < BURST_MAX_C)  burst_cnt <= burst_cnt + BURST_CNT_W'(1);
        end else if (cu_done) begin
            burst_cnt <= '0;
        end
    end

`ifdef TX_AXIS_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cu_pkts <= '0;
            stat_re_pkts <= '0;
        end else if (stat_clr) begin
            stat_cu_pkts <= '0;
            stat_re_pkts <= '0;
        end else begin
            if (cu_done) stat_cu_pkts <= stat_cu_pkts + 32'd1;
            if (re_done) stat_re_pkts <= stat_re_pkts + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_tx_axis_pkt_arbiter.sv
// Directed bench for tx_axis_pkt_arbiter: per-cycle vector table plus burst, reset and stats sequences.
module tb_tx_axis_pkt_arbiter;
    localparam int DW = 32, KW = 4, IW = 10, DSW = 4, UW = 8;

    localparam logic [KW-1:0]  CU_KEEP = 4'hF,   RE_KEEP = 4'h7;
    localparam logic [IW-1:0]  CU_ID   = 10'h11, RE_ID   = 10'h22;
    localparam logic [DSW-1:0] CU_DEST = 4'h3,   RE_DEST = 4'hA;
    localparam logic [UW-1:0]  CU_USER = 8'h5C,  RE_USER = 8'hE5;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] cu_tdata, re_tdata, tx_tdata;
    logic cu_tvalid, cu_tlast, re_tvalid, re_tlast, cu_tready, re_tready;
    logic [KW-1:0] tx_tkeep;
    logic [IW-1:0] tx_tid;
    logic [DSW-1:0] tx_tdest;
    logic [UW-1:0] tx_tuser;
    logic tx_tvalid, tx_tlast, tx_tready;
    logic [1:0] grant;
`ifdef TX_AXIS_ARB_STATS_EN
    logic stat_clr = 1'b0;
    logic [31:0] stat_cu_pkts, stat_re_pkts;
`endif

    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    tx_axis_pkt_arbiter #(
        .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_TX_ID_WIDTH(IW),
        .AXIS_TX_DEST_WIDTH(DSW), .AXIS_TX_USER_WIDTH(UW), .RE_BURST_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cu_tx_axis_tdata(cu_tdata), .cu_tx_axis_tkeep(CU_KEEP), .cu_tx_axis_tvalid(cu_tvalid),
        .cu_tx_axis_tlast(cu_tlast), .cu_tx_axis_tid(CU_ID), .cu_tx_axis_tdest(CU_DEST),
        .cu_tx_axis_tuser(CU_USER), .cu_tx_axis_tready(cu_tready),
        .re_tx_axis_tdata(re_tdata), .re_tx_axis_tkeep(RE_KEEP), .re_tx_axis_tvalid(re_tvalid),
        .re_tx_axis_tlast(re_tlast), .re_tx_axis_tid(RE_ID), .re_tx_axis_tdest(RE_DEST),
        .re_tx_axis_tuser(RE_USER), .re_tx_axis_tready(re_tready),
        .tx_axis_tdata(tx_tdata), .tx_axis_tkeep(tx_tkeep), .tx_axis_tvalid(tx_tvalid),
        .tx_axis_tlast(tx_tlast), .tx_axis_tid(tx_tid), .tx_axis_tdest(tx_tdest),
        .tx_axis_tuser(tx_tuser), .tx_axis_tready(tx_tready), .grant(grant)
`ifdef TX_AXIS_ARB_STATS_EN
       ,.stat_clr(stat_clr), .stat_cu_pkts(stat_cu_pkts), .stat_re_pkts(stat_re_pkts)
`endif
    );

    typedef struct {
        logic       cu_v, cu_l;
        logic [7:0] cu_d;
        logic       re_v, re_l;
        logic [7:0] re_d;
        logic       rdy;
        logic [1:0] e_gnt;
        logic       e_v;
        logic [7:0] e_d;
        logic       e_l, e_cur, e_rer;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic cu_v, logic cu_l, logic [7:0] cu_d,
                                logic re_v, logic re_l, logic [7:0] re_d, logic rdy,
                                logic [1:0] e_gnt, logic e_v, logic [7:0] e_d,
                                logic e_l, logic e_cur, logic e_rer);
        vec_t v;
        v.cu_v = cu_v; v.cu_l = cu_l; v.cu_d = cu_d;
        v.re_v = re_v; v.re_l = re_l; v.re_d = re_d; v.rdy = rdy;
        v.e_gnt = e_gnt; v.e_v = e_v; v.e_d = e_d;
        v.e_l = e_l; v.e_cur = e_cur; v.e_rer = e_rer;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic cl, input logic [7:0] cd,
                         input logic rv, input logic rl, input logic [7:0] rd, input logic rdy);
        cu_tvalid = cv; cu_tlast = cl; cu_tdata = DW'(cd);
        re_tvalid = rv; re_tlast = rl; re_tdata = DW'(rd);
        tx_tready = rdy;
    endtask

    // Expected full output snapshot; sideband follows whichever source is granted.
    function automatic logic [127:0] exp_snap(vec_t v);
        logic [KW-1:0] k; logic [IW-1:0] id; logic [DSW-1:0] ds; logic [UW-1:0] us;
        k = '0; id = '0; ds = '0; us = '0;
        if (v.e_gnt == 2'b01) begin k = CU_KEEP; id = CU_ID; ds = CU_DEST; us = CU_USER; end
        if (v.e_gnt == 2'b10) begin k = RE_KEEP; id = RE_ID; ds = RE_DEST; us = RE_USER; end
        return 128'({v.e_gnt, v.e_v, DW'(v.e_d), v.e_l, v.e_cur, v.e_rer, k, id, ds, us});
    endfunction

    function automatic logic [127:0] act_snap();
        return 128'({grant, tx_tvalid, tx_tdata, tx_tlast, cu_tready, re_tready,
                     tx_tkeep, tx_tid, tx_tdest, tx_tuser});
    endfunction

    initial begin
        // RE-only 3-beat packet
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hA0, 1, 2'b00,0,8'h00,0,0,0));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hA0, 1, 2'b10,1,8'hA0,0,0,1));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hA1, 1, 2'b10,1,8'hA1,0,0,1));
        vecs.push_back(mk(0,0,8'h00, 1,1,8'hA2, 1, 2'b10,1,8'hA2,1,0,1));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00, 1, 2'b00,0,8'h00,0,0,0));
        // CU 4-beat packet, RE arrives at beat 2 and must wait
        vecs.push_back(mk(1,0,8'hC0, 0,0,8'h00, 1, 2'b00,0,8'h00,0,0,0));
        vecs.push_back(mk(1,0,8'hC0, 0,0,8'h00, 1, 2'b01,1,8'hC0,0,1,0));
        vecs.push_back(mk(1,0,8'hC1, 1,1,8'hB0, 1, 2'b01,1,8'hC1,0,1,0));
        vecs.push_back(mk(1,0,8'hC2, 1,1,8'hB0, 1, 2'b01,1,8'hC2,0,1,0));
        vecs.push_back(mk(1,1,8'hC3, 1,1,8'hB0, 1, 2'b01,1,8'hC3,1,1,0));
        vecs.push_back(mk(0,0,8'h00, 1,1,8'hB0, 1, 2'b00,0,8'h00,0,0,0));
        vecs.push_back(mk(0,0,8'h00, 1,1,8'hB0, 1, 2'b10,1,8'hB0,1,0,1));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00, 1, 2'b00,0,8'h00,0,0,0));
        // RE 5-beat packet with downstream ready toggling 1,0,1,0...
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hD0, 1, 2'b00,0,8'h00,0,0,0));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hD0, 1, 2'b10,1,8'hD0,0,0,1));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hD1, 0, 2'b10,1,8'hD1,0,0,0));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hD1, 1, 2'b10,1,8'hD1,0,0,1));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hD2, 0, 2'b10,1,8'hD2,0,0,0));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hD2, 1, 2'b10,1,8'hD2,0,0,1));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hD3, 0, 2'b10,1,8'hD3,0,0,0));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hD3, 1, 2'b10,1,8'hD3,0,0,1));
        vecs.push_back(mk(0,0,8'h00, 1,1,8'hD4, 0, 2'b10,1,8'hD4,1,0,0));
        vecs.push_back(mk(0,0,8'h00, 1,1,8'hD4, 1, 2'b10,1,8'hD4,1,0,1));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00, 1, 2'b00,0,8'h00,0,0,0));

        drive(0,0,8'h00, 0,0,8'h00, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 128'({grant, tx_tvalid, cu_tready, re_tready}), 128'(5'b0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].cu_v, vecs[i].cu_l, vecs[i].cu_d,
                  vecs[i].re_v, vecs[i].re_l, vecs[i].re_d, vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d", i), act_snap(), exp_snap(vecs[i]));
        end

        // Both sources always valid, 1-beat packets: RE x4 then CU, repeating
        begin
            int n = 0;
            @(negedge clk);
            drive(1,1,8'hCC, 1,1,8'hEE, 1);
            for (int cyc = 0; cyc < 60 && n < 12; cyc++) begin
                #1;
                if (tx_tvalid) begin
                    chk($sformatf("burst_pkt%0d", n), 128'({grant, tx_tdata}),
                        (n % 5 == 4) ? 128'({2'b01, DW'(8'hCC)}) : 128'({2'b10, DW'(8'hEE)}));
                    n++;
                end
                @(negedge clk);
            end
            chk("burst_count", 128'(n), 128'(12));
        end

        // Reset in the middle of a CU packet; burst count is nonzero going in
        drive(1,0,8'hF0, 0,0,8'h00, 1);
        @(negedge clk);
        #1 chk("rst_beat1", 128'({grant, tx_tvalid, tx_tdata}), 128'({2'b01, 1'b1, DW'(8'hF0)}));
        @(negedge clk);
        drive(1,0,8'hF1, 0,0,8'h00, 1);
        #1 chk("rst_beat2", 128'({tx_tvalid, tx_tdata, cu_tready}), 128'({1'b1, DW'(8'hF1), 1'b1}));
        rst_n = 1'b0;
        #1 chk("rst_async", 128'({grant, tx_tvalid, cu_tready, re_tready}), 128'(5'b0));
        @(negedge clk);
        drive(0,0,8'h00, 0,0,8'h00, 1);
        rst_n = 1'b1;
        #1 chk("rst_after", 128'({grant, dut.burst_cnt}), 128'(0));
        // With a cleared burst count, contention goes to RE
        @(negedge clk);
        drive(1,1,8'h1C, 1,1,8'h1E, 1);
        @(negedge clk);
        #1 chk("post_rst_arb", 128'({grant, tx_tdata}), 128'({2'b10, DW'(8'h1E)}));
        @(posedge clk);
        #1 drive(0,0,8'h00, 0,0,8'h00, 1);
        repeat (2) @(posedge clk);

`ifdef TX_AXIS_ARB_STATS_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < 16; p++) begin
            @(negedge clk);
            if (p < 7) drive(1,1,8'h71, 0,0,8'h00, 1);
            else       drive(0,0,8'h00, 1,1,8'h72, 1);
            repeat (2) @(posedge clk);
            #1 drive(0,0,8'h00, 0,0,8'h00, 1);
        end
        @(negedge clk);
        chk("stat_counts", 128'({stat_cu_pkts, stat_re_pkts}), 128'({32'd7, 32'd9}));
        stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        chk("stat_clr", 128'({stat_cu_pkts, stat_re_pkts}), 128'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
